// File: rtl/mmio_uart_ctrl_pkg.sv
// Register offsets and status-word bit positions for the MMIO/UART window.
// Offsets are added to the instance's base address; status fields are indexed by bit position.
package mmio_uart_ctrl_pkg;

    localparam logic [31:0] MMIO_STATUS     = 32'h00;
    localparam logic [31:0] MMIO_RX_DATA    = 32'h04;
    localparam logic [31:0] MMIO_TX_DATA    = 32'h08;
    localparam logic [31:0] MMIO_CYCLE_CNT  = 32'h10;
    localparam logic [31:0] MMIO_INST_CNT   = 32'h14;
    localparam logic [31:0] MMIO_CNT_RST    = 32'h18;
    localparam logic [31:0] MMIO_IRQ_EN_REG = 32'h1C;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_OVF       = 2;
    localparam int ST_RX_UDF       = 3;
    localparam int ST_RX_OCC_LSB   = 8;
    localparam int ST_TX_OCC_LSB   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
// Zero-latency read of head; push accepted when not full or when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                cnt <= cnt + (AW+1)'(1);
            else if (!do_push && do_pop)
                cnt <= cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller: UART RX/TX FIFOs, cycle/instruction counters; loads return one cycle after re.
// Optional MMIO_UART_IRQ_EN adds the 0x1C irq-enable register and a registered irq output.
module mmio_uart_ctrl
    import mmio_uart_ctrl_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
    parameter int          RX_FIFO_DEPTH = 8,
    parameter int          TX_FIFO_DEPTH = 8,
    parameter int          CNT_WIDTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int RX_CW = $clog2(RX_FIFO_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic [31:0]          off;
    logic                 store;
    logic                 st_rd, rx_rd, tx_wr, cnt_clr;
    logic                 rx_full, rx_empty, tx_full, tx_empty;
    logic [RX_CW-1:0]     rx_cnt;
    logic [TX_CW-1:0]     tx_cnt;
    logic [7:0]           rx_head;
    logic                 tx_pop;
    logic                 tx_ovf, rx_udf;
    logic [CNT_WIDTH-1:0] cyc_cnt, inst_cnt;
    logic [31:0]          status_word, cyc_ext, inst_ext, rd_mux;
    logic                 unused_wdata;

    // Modular subtraction is a bijection, so off==K is exactly addr==MMIO_BASE+K.
    assign off      = addr - MMIO_BASE;
    assign store    = (|wbe) & ~re;
    assign st_rd    = re & (off == MMIO_STATUS);
    assign rx_rd    = re & (off == MMIO_RX_DATA);
    assign tx_wr    = store & (off == MMIO_TX_DATA);
    assign cnt_clr  = store & (off == MMIO_CNT_RST);
    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign unused_wdata = ^wdata[31:8];

    sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid & rx_ready),
        .din   (rx_data),
        .pop   (rx_rd),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

    // A status read reports the flags and clears them on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf & ~st_rd) | (tx_wr & tx_full & ~tx_pop);
            rx_udf <= (rx_udf & ~st_rd) | (rx_rd & rx_empty);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + CNT_WIDTH'(1);
            inst_cnt <= inst_cnt + CNT_WIDTH'(inst_retire);
        end
    end

`ifdef MMIO_UART_IRQ_EN
    logic [1:0] irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (store && off == MMIO_IRQ_EN_REG) irq_en <= wdata[1:0];
            irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        status_word = '0;
        status_word[ST_TX_NOT_FULL]  = ~tx_full;
        status_word[ST_RX_NOT_EMPTY] = ~rx_empty;
        status_word[ST_TX_OVF]       = tx_ovf;
        status_word[ST_RX_UDF]       = rx_udf;
        status_word[ST_RX_OCC_LSB +: RX_CW] = rx_cnt;
        status_word[ST_TX_OCC_LSB +: TX_CW] = tx_cnt;
        cyc_ext  = '0;
        cyc_ext[CNT_WIDTH-1:0]  = cyc_cnt;
        inst_ext = '0;
        inst_ext[CNT_WIDTH-1:0] = inst_cnt;
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            MMIO_STATUS:     rd_mux = status_word;
            MMIO_RX_DATA:    rd_mux = rx_empty ? 32'h0 : {24'h0, rx_head};
            MMIO_CYCLE_CNT:  rd_mux = cyc_ext;
            MMIO_INST_CNT:   rd_mux = inst_ext;
`ifdef MMIO_UART_IRQ_EN
            MMIO_IRQ_EN_REG: rd_mux = {30'h0, irq_en};
`else
            MMIO_IRQ_EN_REG: rd_mux = 32'h0;
`endif
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= rd_mux;
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Bench for mmio_uart_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_mmio_uart_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          DEP  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wbe = '0;
    logic        re = 1'b0, inst_retire = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [31:0] rdata;
    logic        rx_ready, tx_valid, irq;
    logic [7:0]  tx_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit seen99   = 1'b0;

    mmio_uart_ctrl dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wbe(wbe), .re(re),
        .rdata(rdata), .inst_retire(inst_retire), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queues, flag bits and plain integer counters.
    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    logic [31:0] m_rdata, m_cyc, m_inst, m_off;
    logic        m_txo, m_rxu, m_irq, m_store, m_txpop;
    logic [1:0]  m_en;
    int          m_rxn, m_txn;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rx.delete(); m_tx.delete();
            m_rdata = 0; m_cyc = 0; m_inst = 0;
            m_txo = 0; m_rxu = 0; m_irq = 0; m_en = 0;
        end else begin
            m_rxn   = m_rx.size();
            m_txn   = m_tx.size();
            m_off   = addr - BASE;
            m_store = (wbe != 0) && !re;
`ifdef MMIO_UART_IRQ_EN
            m_irq = (m_en[0] && m_rxn > 0) || (m_en[1] && m_txn == 0);
`endif
            if (re) begin
                case (m_off)
                    32'h00: m_rdata = {8'h00, 8'(m_txn), 8'(m_rxn), 4'h0, m_rxu, m_txo,
                                       1'(m_rxn != 0), 1'(m_txn != DEP)};
                    32'h04: m_rdata = (m_rxn > 0) ? {24'h0, m_rx[0]} : 32'h0;
                    32'h10: m_rdata = m_cyc;
                    32'h14: m_rdata = m_inst;
`ifdef MMIO_UART_IRQ_EN
                    32'h1C: m_rdata = {30'h0, m_en};
`endif
                    default: m_rdata = 0;
                endcase
            end
            if (re && m_off == 32'h00) begin m_txo = 0; m_rxu = 0; end
            if (re && m_off == 32'h04) begin
                if (m_rxn > 0) void'(m_rx.pop_front());
                else m_rxu = 1;
            end
            if (rx_valid && m_rxn < DEP) m_rx.push_back(rx_data);
            m_txpop = (m_txn > 0) && tx_ready;
            if (m_txpop) void'(m_tx.pop_front());
            if (m_store && m_off == 32'h08) begin
                if (m_txn < DEP || m_txpop) m_tx.push_back(wdata[7:0]);
                else m_txo = 1;
            end
            if (m_store && m_off == 32'h18) begin
                m_cyc = 0; m_inst = 0;
            end else begin
                m_cyc  = m_cyc + 1;
                m_inst = m_inst + 32'(inst_retire);
            end
`ifdef MMIO_UART_IRQ_EN
            if (m_store && m_off == 32'h1C) m_en = wdata[1:0];
`endif
        end
    end

    // Outputs change only on posedge (or rst), so the opposite edge is a stable sample point.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdata", rdata, m_rdata);
            chk("tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
            if (m_tx.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_tx[0]));
            chk("rx_ready", 32'(rx_ready), 32'(m_rx.size() < DEP));
            chk("irq", 32'(irq), 32'(m_irq));
            if (tx_valid && tx_data == 8'h99) seen99 = 1'b1;
        end
    end

    task automatic wr(input logic [31:0] o, input logic [31:0] d);
        addr = BASE + o; wdata = d; wbe = 4'hF;
        @(negedge clk);
        wbe = 4'h0;
    endtask

    task automatic rd(input logic [31:0] o);
        addr = BASE + o; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_rx_ready", 32'(rx_ready), 32'h1);
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rd(32'h00);
        chk("status_after_reset", rdata, 32'h0000_0001);

        wr(32'h08, 32'h41); wr(32'h08, 32'h42); wr(32'h08, 32'h43);
        rd(32'h00);
        chk("status_tx3", rdata, 32'h0003_0001);
        tx_ready = 1'b1;
        chk("tx_byte0", 32'(tx_data), 32'h41); @(negedge clk);
        chk("tx_byte1", 32'(tx_data), 32'h42); @(negedge clk);
        chk("tx_byte2", 32'(tx_data), 32'h43); @(negedge clk);
        chk("tx_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        for (int i = 0; i < DEP; i++) wr(32'h08, 32'h50 + 32'(i));
        wr(32'h08, 32'h99);
        rd(32'h00);
        chk("status_tx_ovf", rdata, 32'h0008_0004);
        rd(32'h00);
        chk("status_ovf_cleared", rdata, 32'h0008_0000);
        tx_ready = 1'b1;
        repeat (DEP + 1) @(negedge clk);
        tx_ready = 1'b0;
        chk("tx_empty_after_fill", 32'(tx_valid), 32'h0);

        rx_valid = 1'b1; rx_data = 8'h10; @(negedge clk);
        rx_data = 8'h20; @(negedge clk);
        rx_valid = 1'b0;
        rd(32'h00);
        chk("status_rx2", rdata, 32'h0000_0203);
        rd(32'h04); chk("rx_read0", rdata, 32'h10);
        rd(32'h04); chk("rx_read1", rdata, 32'h20);
        rd(32'h04); chk("rx_read_empty", rdata, 32'h0);
        rd(32'h00); chk("status_rx_udf", rdata, 32'h0000_0009);
        rd(32'h00); chk("status_udf_cleared", rdata, 32'h0000_0001);

        rx_valid = 1'b1;
        for (int i = 0; i <= DEP; i++) begin
            rx_data = 8'(i); @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("rx_full_not_ready", 32'(rx_ready), 32'h0);
        for (int i = 0; i < DEP; i++) rd(32'h04);
        chk("rx_last_of_full", rdata, 32'h07);

        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 1); @(negedge clk);
        end
        inst_retire = 1'b0;
        rd(32'h14); chk("inst_cnt_50", rdata, 32'd50);
        inst_retire = 1'b1;
        wr(32'h18, 32'h0);
        inst_retire = 1'b0;
        rd(32'h10); chk("cyc_after_clear", rdata, 32'h0);
        rd(32'h14); chk("inst_after_clear", rdata, 32'h0);
        rd(32'h10); chk("cyc_counts_again", rdata, 32'd2);

        force dut.cyc_cnt = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt;
        addr = BASE + 32'h10; re = 1'b1;
        @(negedge clk); chk("cyc_preload", rdata, 32'hFFFF_FFFF);
        @(negedge clk); chk("cyc_wrapped", rdata, 32'h0);
        re = 1'b0;

`ifdef MMIO_UART_IRQ_EN
        wr(32'h1C, 32'h1);
        rd(32'h1C); chk("irq_en_readback", rdata, 32'h1);
        rx_valid = 1'b1; rx_data = 8'h5A; @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk); chk("irq_rx_set", 32'(irq), 32'h1);
        rd(32'h04);
        @(negedge clk); chk("irq_rx_clear", 32'(irq), 32'h0);
        wr(32'h1C, 32'h2);
        @(negedge clk); chk("irq_tx_empty", 32'(irq), 32'h1);
        wr(32'h1C, 32'h0);
        @(negedge clk); chk("irq_disabled", 32'(irq), 32'h0);
`else
        wr(32'h1C, 32'h3);
        rd(32'h1C); chk("irq_en_absent", rdata, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h5A; @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("irq_tied_low", 32'(irq), 32'h0);
        rd(32'h04);
`endif

        wr(32'h08, 32'hAA); wr(32'h08, 32'hBB);
        rx_valid = 1'b1; rx_data = 8'h77; @(negedge clk);
        rx_valid = 1'b0;
        rd(32'h00); chk("status_before_rst", rdata, 32'h0002_0103);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("async_rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(32'h00); chk("status_after_mid_rst", rdata, 32'h0000_0001);

        chk("no_0x99_on_tx", 32'(seen99), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
